pdm_cic_decimator: RTL and testbench

//  Decimating CIC filter downstream of the PDM microphone clock/capture stage. Consumes the 1-bit PDM stream
//  (one strobe per PDM clock) and produces signed 16-bit PCM samples at PDM rate / decim_ratio. A shared

---
 rtl/pdm_cic_decimator_pkg.sv | 32 +++
 rtl/pdm_cic_decimator_if.sv | 9 +
 rtl/pdm_cic_decimator_integrator.sv | 39 +++
 rtl/pdm_cic_decimator.sv | 143 ++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pdm_cic_decimator_pkg.sv
// Shared definitions for the PDM CIC decimator: default sizes, comb FSM states,
// and helpers for output scaling and decimation-ratio clamping.
package pdm_pkg;
  localparam int CIC_ORDER = 3;
  localparam int CIC_RMAX  = 64;
  localparam int CIC_ACC_W = 20;
  localparam int OUT_W     = 16;
  localparam int PCM_MAX   = (1 << (OUT_W - 1)) - 1;
  localparam int PCM_MIN   = -(1 << (OUT_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMB = 2'd1,
    OUT  = 2'd2
  } comb_state_t;

  // Operates on a sign-extended 32-bit copy, so shifts past ACC_W settle at 0 / -1.
  function automatic logic signed [OUT_W-1:0] shift_saturate(input logic signed [31:0] v,
                                                             input logic [4:0] sh);
    logic signed [31:0] r;
    r = v >>> sh;
    if (r > PCM_MAX) return OUT_W'(PCM_MAX);
    if (r < PCM_MIN) return OUT_W'(PCM_MIN);
    return r[OUT_W-1:0];
  endfunction

  function automatic logic [6:0] clamp_ratio(input logic [6:0] r, input int rmax);
    if (r < 7'd2) return 7'd2;
    if (int'(r) > rmax) return 7'(rmax);
    return r;
  endfunction
endpackage

// File: rtl/pdm_cic_decimator_if.sv
// PCM output handshake between the decimator and its consumer.
interface pdm_cic_decimator_if #(parameter int OUT_W = 16);
  logic signed [OUT_W-1:0] pcm_data;
  logic                    pcm_valid;
  logic                    pcm_ready;

  modport master (output pcm_data, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_cic_decimator_integrator.sv
// Pipelined CIC integrator chain; each stage adds the previous stage's old value on a strobe.
module pdm_cic_integrator #(
  parameter int ORDER = 3,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             strobe_i,
  input  logic             pdm_bit_i,
  output logic [ACC_W-1:0] integ_o
);
  logic [ACC_W-1:0] x;

  assign x = pdm_bit_i ? ACC_W'(1) : '1;

  for (genvar gi = 0; gi < ORDER; gi++) begin : g_stage
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] addend;

    if (gi == 0) begin : g_first
      assign addend = x;
    end else begin : g_next
      assign addend = g_stage[gi-1].acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (flush_i) begin
        acc_q <= '0;
      end else if (strobe_i) begin
        acc_q <= acc_q + addend;
      end
    end
  end

  assign integ_o = g_stage[ORDER-1].acc_q;
endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM CIC decimator: integrators per PDM strobe, one shared subtractor stepping
// through the comb stages once per decimation event, then scale/saturate into a holding register.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int ORDER = CIC_ORDER,
  parameter int RMAX  = CIC_RMAX,
  parameter int ACC_W = CIC_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       pdm_data,
  input  logic                       pdm_strobe,
  input  logic [6:0]                 decim_ratio,
  input  logic [4:0]                 out_shift,
  pdm_cic_decimator_if.master        pcm,
  output logic                       overrun,
  input  logic                       clr_overrun
);
  localparam int STG_W  = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int WARM_W = $clog2(ORDER + 1);

  comb_state_t             state_q, state_d;
  logic [STG_W-1:0]        stage_q, stage_d;
  logic [WARM_W-1:0]       warm_q, warm_d;
  logic [ACC_W-1:0]        v_q, v_d, sub_b, integ;
  logic [ACC_W-1:0]        dly_q [ORDER];
  logic [ACC_W-1:0]        dly_d [ORDER];
  logic [6:0]              cnt_q, r_lat_q, r_eff;
  logic                    en_q, req_q;
  logic                    strobe, wrap, load_out, drop, hs, ovr_set;
  logic signed [OUT_W-1:0] pcm_data_q, sample;
  logic                    pcm_valid_q, overrun_q;

  assign strobe = pdm_strobe & enable;
  // On the first enabled cycle the freshly clamped ratio is used directly.
  assign r_eff  = (enable && !en_q) ? clamp_ratio(decim_ratio, RMAX) : r_lat_q;
  assign wrap   = strobe && (cnt_q == r_eff - 7'd1);

  pdm_cic_integrator #(.ORDER(ORDER), .ACC_W(ACC_W)) u_integ (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (!enable),
    .strobe_i  (strobe),
    .pdm_bit_i (pdm_data),
    .integ_o   (integ)
  );

  assign sample = shift_saturate(32'(signed'(v_q)), out_shift);

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    warm_d   = warm_q;
    v_d      = v_q;
    load_out = 1'b0;
    sub_b    = '0;
    for (int k = 0; k < ORDER; k++) begin
      dly_d[k] = dly_q[k];
      if (stage_q == STG_W'(k)) sub_b = dly_q[k];
    end
    case (state_q)
      IDLE: begin
        if (req_q) begin
          v_d     = integ;
          stage_d = '0;
          state_d = COMB;
        end
      end
      COMB: begin
        for (int k = 0; k < ORDER; k++) begin
          if (stage_q == STG_W'(k)) dly_d[k] = v_q;
        end
        v_d = v_q - sub_b;
        if (stage_q == STG_W'(ORDER - 1)) state_d = OUT;
        else                              stage_d = stage_q + 1'b1;
      end
      OUT: begin
        state_d = IDLE;
        if (warm_q < WARM_W'(ORDER)) warm_d = warm_q + 1'b1;
        else                         load_out = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop    = req_q && (state_q != IDLE);
  assign hs      = pcm_valid_q & pcm.pcm_ready;
  assign ovr_set = drop | (load_out & pcm_valid_q & ~pcm.pcm_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      warm_q      <= '0;
      v_q         <= '0;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      cnt_q       <= '0;
      r_lat_q     <= '0;
      en_q        <= 1'b0;
      req_q       <= 1'b0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (!enable) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      warm_q      <= '0;
      v_q         <= '0;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      cnt_q       <= '0;
      r_lat_q     <= '0;
      en_q        <= 1'b0;
      req_q       <= 1'b0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      if (clr_overrun) overrun_q <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      req_q   <= wrap;
      if (strobe) cnt_q <= wrap ? 7'd0 : cnt_q + 7'd1;
      r_lat_q <= wrap ? clamp_ratio(decim_ratio, RMAX) : r_eff;
      state_q <= state_d;
      stage_q <= stage_d;
      warm_q  <= warm_d;
      v_q     <= v_d;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= dly_d[k];
      if (load_out) begin
        pcm_data_q  <= sample;
        pcm_valid_q <= 1'b1;
      end else if (hs) begin
        pcm_valid_q <= 1'b0;
      end
      if (ovr_set)          overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  assign pcm.pcm_data  = pcm_data_q;
  assign pcm.pcm_valid = pcm_valid_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for the PDM CIC decimator with hand-computed CIC gains (R^3 >>> shift).
module tb_pdm_cic_decimator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pdm_data = 1'b0;
  logic       pdm_strobe = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [6:0] decim_ratio = 7'd64;
  logic [4:0] out_shift = 5'd4;
  logic       overrun;

  pdm_cic_decimator_if #(.OUT_W(16)) bus ();

  pdm_cic_decimator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pdm_data    (pdm_data),
    .pdm_strobe  (pdm_strobe),
    .decim_ratio (decim_ratio),
    .out_shift   (out_shift),
    .pcm         (bus),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sidx    = 0;
  int mode    = 0;
  logic signed [15:0] samples [$];

  always @(negedge clk) begin
    if (rst_n && bus.pcm_valid && bus.pcm_ready) samples.push_back(bus.pcm_data);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // mode 0: all ones, 1: all zeros, 2: alternating 1010
  task automatic strobe_one(input int gap);
    @(negedge clk);
    pdm_data   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : (sidx % 2 == 0);
    pdm_strobe = 1'b1;
    sidx++;
    @(negedge clk);
    pdm_strobe = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive(input int n);
    repeat (n) strobe_one(4);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic restart(input int ratio, input int shift, input int m);
    @(negedge clk);
    enable      = 1'b0;
    decim_ratio = 7'(ratio);
    out_shift   = 5'(shift);
    mode        = m;
    sidx        = 0;
    @(negedge clk);
    enable = 1'b1;
    samples.delete();
  endtask

  // Eight events: first three discarded, event 4 may be transient, events 5..8 steady.
  task automatic run_steady(input string tag, input int ratio, input int shift, input int m,
                            input int exp);
    restart(ratio, shift, m);
    drive(8 * ratio);
    settle();
    check_eq({tag, "_count"}, samples.size(), 5);
    for (int i = 1; i < samples.size(); i++) check_eq(tag, samples[i], exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.pcm_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_data", bus.pcm_data, 0);
    check_eq("reset_valid", bus.pcm_valid, 0);
    check_eq("reset_overrun", overrun, 0);
    rst_n = 1'b1;

    run_steady("ones_r64_s4", 64, 4, 0, 16384);
    run_steady("ones_r64_s3_sat", 64, 3, 0, 32767);
    run_steady("zeros_r64_s4", 64, 4, 1, -16384);
    run_steady("alt_r64_s4", 64, 4, 2, 0);

    // R=8 then a mid-frame switch to 16 that must wait for the current wrap
    restart(8, 0, 0);
    drive(80);
    settle();
    check_eq("r8_count", samples.size(), 7);
    if (samples.size() == 7) check_eq("r8_steady", samples[6], 512);
    drive(4);
    decim_ratio = 7'd16;
    drive(100);
    settle();
    check_eq("r16_switch_count", samples.size(), 14);
    if (samples.size() > 0) check_eq("r16_steady", samples[samples.size()-1], 4096);

    // async reset in the middle of a comb run
    drive(15);
    strobe_one(0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midcomb_rst_data", bus.pcm_data, 0);
    check_eq("midcomb_rst_valid", bus.pcm_valid, 0);
    check_eq("midcomb_rst_overrun", overrun, 0);
    @(negedge clk);
    samples.delete();
    rst_n = 1'b1;
    drive(48);
    settle();
    check_eq("rst_warmup_count", samples.size(), 0);
    drive(32);
    settle();
    check_eq("rst_after_count", samples.size(), 2);
    if (samples.size() == 2) check_eq("rst_after_value", samples[1], 4096);

    // back-pressure: two outputs without ready
    restart(8, 0, 0);
    bus.pcm_ready = 1'b0;
    drive(32);
    settle();
    check_eq("hold_valid", bus.pcm_valid, 1);
    check_eq("hold_data", bus.pcm_data, 512);
    check_eq("hold_overrun", overrun, 0);
    out_shift = 5'd1;
    drive(8);
    settle();
    check_eq("ovr_valid", bus.pcm_valid, 1);
    check_eq("ovr_data_second", bus.pcm_data, 256);
    check_eq("ovr_flag", overrun, 1);
    bus.pcm_ready = 1'b1;
    @(negedge clk);
    check_eq("ovr_consume_valid", bus.pcm_valid, 0);

    // one-cycle enable drop: flush, overrun held, warm-up repeats
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check_eq("flush_overrun_held", overrun, 1);
    check_eq("flush_valid", bus.pcm_valid, 0);
    check_eq("flush_data", bus.pcm_data, 0);
    samples.delete();
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check_eq("clr_overrun", overrun, 0);
    out_shift = 5'd0;
    drive(24);
    settle();
    check_eq("flush_warmup_count", samples.size(), 0);
    drive(16);
    settle();
    check_eq("flush_after_count", samples.size(), 2);
    if (samples.size() == 2) check_eq("flush_after_value", samples[1], 512);
    check_eq("final_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
